// File: rtl/shift_frame_pkg.sv
// Shared widths, shift-order constants and a width helper for the serial frame loader.
package shift_frame_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEPTH_DEFAULT = 256;
  localparam int unsigned FRAME_CNT_W   = $clog2(DEPTH_DEFAULT);
  localparam int unsigned BITS_LEFT_W   = 4;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } shift_order_e;

  // Counter width for a modulo-n counter; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_frame_loader_pacer.sv
// frame_pacer: bit-rate divider and frame position counter for the serial loader.
module frame_pacer
  import shift_frame_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic active,
  input  logic load,
  output logic strobe_c,
  output logic frame_open_c,
  output logic frame_done
);

  localparam int unsigned DIV_W = cnt_width(CLK_DIV);
  localparam int unsigned CNT_W = (DEPTH == DEPTH_DEFAULT) ? FRAME_CNT_W : cnt_width(DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] frame_cnt;

  assign strobe_c     = active && (div_cnt == DIV_LAST);
  assign frame_open_c = (frame_cnt != '0);

  // A byte load restarts the divider so its first bit lands CLK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      div_cnt    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        div_cnt <= '0;
      end else if (active) begin
        div_cnt <= strobe_c ? '0 : DIV_W'(div_cnt + 1'b1);
      end
      if (strobe_c) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= CNT_W'(frame_cnt + 1'b1);
        end
      end
    end
  end

endmodule

// File: rtl/shift_frame_loader.sv
// Byte-to-serial feeder for the downstream shift-register stage, with holding buffer and pacing.
// Define LSB_FIRST_EN to shift each byte LSB-first instead of MSB-first.
module shift_frame_loader
  import shift_frame_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              sr_din,
  output logic              sr_clken,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

`ifdef LSB_FIRST_EN
  localparam shift_order_e ORDER = LSB_FIRST;
`else
  localparam shift_order_e ORDER = MSB_FIRST;
`endif

  logic [BYTE_W-1:0]      hold_q, hold_d;
  logic                   hold_full, hold_full_d;
  logic [BYTE_W-1:0]      shift_q, shift_d, shift_nxt_c;
  logic [BITS_LEFT_W-1:0] bits_left, bits_left_d;
  logic                   accept_c, load_c, strobe_c, frame_open_c, out_bit_c;

  assign in_ready = !hold_full && !flush && !rst;
  assign accept_c = in_valid && in_ready;
  // Reload on the last strobe of a byte too, so consecutive bytes stream without a gap.
  assign load_c   = hold_full && ((bits_left == '0) || ((bits_left == BITS_LEFT_W'(1)) && strobe_c));

  assign out_bit_c   = (ORDER == LSB_FIRST) ? shift_q[0] : shift_q[BYTE_W-1];
  assign shift_nxt_c = (ORDER == LSB_FIRST) ? {1'b0, shift_q[BYTE_W-1:1]}
                                            : {shift_q[BYTE_W-2:0], 1'b0};

  frame_pacer #(
    .DEPTH   (DEPTH),
    .CLK_DIV (CLK_DIV)
  ) u_pacer (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .active       (bits_left != '0),
    .load         (load_c),
    .strobe_c     (strobe_c),
    .frame_open_c (frame_open_c),
    .frame_done   (frame_done)
  );

  // Next state of the hold/shift datapath.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full;
    shift_d     = shift_q;
    bits_left_d = bits_left;
    if (load_c) begin
      shift_d     = hold_q;
      bits_left_d = BITS_LEFT_W'(BYTE_W);
      hold_full_d = 1'b0;
    end else if (strobe_c) begin
      shift_d     = shift_nxt_c;
      bits_left_d = BITS_LEFT_W'(bits_left - 1'b1);
    end
    if (accept_c) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      shift_q   <= '0;
      bits_left <= '0;
      sr_clken  <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      if (rst) begin
        sr_din <= 1'b0;
      end
    end else begin
      hold_q    <= hold_d;
      hold_full <= hold_full_d;
      shift_q   <= shift_d;
      bits_left <= bits_left_d;
      sr_clken  <= strobe_c;
      busy      <= hold_full_d || (bits_left_d != '0);
      if (strobe_c) begin
        sr_din <= out_bit_c;
      end
      // Starved mid-frame: nothing shifting and nothing waiting.
      if (frame_open_c && (bits_left == '0) && !hold_full) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_frame_loader.sv
// Randomized and directed bench for shift_frame_loader against a byte-level timing model.
module tb_shift_frame_loader;

  localparam int unsigned DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data    [2];
  logic       in_valid   [2];
  logic       in_ready   [2];
  logic       flush      [2];
  logic       sr_din     [2];
  logic       sr_clken   [2];
  logic       busy       [2];
  logic       frame_done [2];
  logic       underrun   [2];

  always #5 clk = ~clk;

  shift_frame_loader #(.DEPTH(DEPTH), .CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .flush(flush[0]), .sr_din(sr_din[0]), .sr_clken(sr_clken[0]), .busy(busy[0]),
    .frame_done(frame_done[0]), .underrun(underrun[0])
  );

  shift_frame_loader #(.DEPTH(DEPTH), .CLK_DIV(3)) u_dut_div3 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .flush(flush[1]), .sr_din(sr_din[1]), .sr_clken(sr_clken[1]), .busy(busy[1]),
    .frame_done(frame_done[1]), .underrun(underrun[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int smp      = 0;
  int sel      = 0;

  int         acc_cyc  [$];
  logic [7:0] acc_byte [$];
  int         strb_cyc [$];
  logic       strb_bit [$];
  logic       strb_busy[$];
  int         fd_cyc   [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor of the selected DUT; accepts are logged with the index of the coming edge.
  always @(negedge clk) begin
    smp = smp + 1;
    if (in_valid[sel] && in_ready[sel]) begin
      acc_cyc.push_back(smp);
      acc_byte.push_back(in_data[sel]);
    end
    if (sr_clken[sel]) begin
      strb_cyc.push_back(smp);
      strb_bit.push_back(sr_din[sel]);
      strb_busy.push_back(busy[sel]);
    end
    if (frame_done[sel]) fd_cyc.push_back(smp);
  end

  function automatic logic exp_bit(input logic [7:0] b, input int j);
`ifdef LSB_FIRST_EN
    return b[j];
`else
    return b[7-j];
`endif
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_byte.delete();
    strb_cyc.delete(); strb_bit.delete(); strb_busy.delete(); fd_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input int k);
    flush[k] = 1'b1;
    @(posedge clk); #1;
    flush[k] = 1'b0;
    clear_logs();
  endtask

  task automatic send(input int k, input logic [7:0] b);
    int t;
    t = 0;
    in_data[k]  = b;
    in_valid[k] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[k] && t < 200);
    if (t >= 200) check("send_ready", 32'(in_ready[k]), 32'd1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  // Byte-level model: a byte enters the shifter one edge after acceptance, or on the
  // previous byte's last strobe if it was already waiting; bit j strobes j*div edges later.
  task automatic check_stream(input string tag, input int div);
    int   exp_c[$];
    logic exp_b[$];
    int   exp_fd[$];
    int   s8, ld, e, k, bad_t, bad_b, n;
    s8 = -1000; k = 0; bad_t = 0; bad_b = 0;
    foreach (acc_cyc[i]) begin
      ld = (i > 0 && acc_cyc[i] < s8) ? s8 : acc_cyc[i] + 1;
      for (int j = 0; j < 8; j++) begin
        e = ld + (j + 1) * div;
        exp_c.push_back(e + 1);
        exp_b.push_back(exp_bit(acc_byte[i], j));
        k++;
        if (k % DEPTH == 0) exp_fd.push_back(e + 1);
      end
      s8 = ld + 8 * div;
    end
    check({tag, "_nstrobe"}, 32'(strb_cyc.size()), 32'(exp_c.size()));
    n = (strb_cyc.size() < exp_c.size()) ? strb_cyc.size() : exp_c.size();
    for (int i = 0; i < n; i++) begin
      if (strb_cyc[i] != exp_c[i]) bad_t++;
      if (strb_bit[i] !== exp_b[i]) bad_b++;
    end
    check({tag, "_timing_errs"}, 32'(bad_t), 32'd0);
    check({tag, "_bit_errs"}, 32'(bad_b), 32'd0);
    check({tag, "_nframes"}, 32'(fd_cyc.size()), 32'(exp_fd.size()));
    if (fd_cyc.size() == exp_fd.size() && exp_fd.size() > 0)
      check({tag, "_frame_cyc"}, 32'(fd_cyc[0]), 32'(exp_fd[0]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, a0, nb, gap;
    logic [7:0] b;
    for (int k = 0; k < 2; k++) begin
      in_data[k] = '0; in_valid[k] = 1'b0; flush[k] = 1'b0;
    end
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h77;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", 32'(in_ready[k]), 32'd0);
      check("rst_sr_din", 32'(sr_din[k]), 32'd0);
      check("rst_sr_clken", 32'(sr_clken[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_frame_done", 32'(frame_done[k]), 32'd0);
      check("rst_underrun", 32'(underrun[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("post_rst_in_ready3", 32'(in_ready[1]), 32'd1);
    @(posedge clk); #1;
    clear_logs();

    // Single byte 0xA5 at one clock per bit.
    sel = 0;
    send(0, 8'hA5);
    idle(15);
    check_stream("a5", 1);
    if (strb_cyc.size() == 8 && acc_cyc.size() == 1) begin
      check("a5_latency", 32'(strb_cyc[0] - acc_cyc[0]), 32'd3);
      check("a5_span", 32'(strb_cyc[7] - strb_cyc[0]), 32'd7);
      for (int j = 0; j < 8; j++) check("a5_bit", 32'(strb_bit[j]), 32'(exp_bit(8'hA5, j)));
      check("a5_busy_mid", 32'(strb_busy[6]), 32'd1);
      check("a5_busy_end", 32'(strb_busy[7]), 32'd0);
    end
    check("a5_underrun", 32'(underrun[0]), 32'd1);

    // 32 back-to-back bytes fill exactly one frame.
    do_flush(0);
    for (int i = 0; i < 32; i++) send(0, 8'(i));
    idle(20);
    check_stream("stream", 1);
    if (strb_cyc.size() == 256)
      check("stream_gapless", 32'(strb_cyc[255] - strb_cyc[0]), 32'd255);
    check("stream_underrun", 32'(underrun[0]), 32'd0);

    // Slow pacing: 0xFF at three clocks per bit.
    sel = 1;
    do_flush(1);
    send(1, 8'hFF);
    @(negedge clk);
    check("div3_ready_held", 32'(in_ready[1]), 32'd0);
    @(negedge clk);
    check("div3_ready_back", 32'(in_ready[1]), 32'd1);
    idle(40);
    check_stream("ff_div3", 3);
    if (strb_cyc.size() >= 2) check("div3_spacing", 32'(strb_cyc[1] - strb_cyc[0]), 32'd3);

    // Starvation mid-frame, then flush and a fresh full frame.
    sel = 0;
    do_flush(0);
    send(0, 8'h5A);
    send(0, 8'hC3);
    idle(30);
    check_stream("starve", 1);
    check("starve_underrun", 32'(underrun[0]), 32'd1);
    idle(10);
    check("starve_sticky", 32'(underrun[0]), 32'd1);
    do_flush(0);
    @(negedge clk);
    check("flush_clr_underrun", 32'(underrun[0]), 32'd0);
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 32; i++) send(0, 8'($urandom));
    idle(20);
    check_stream("refill", 1);

    // Flush in the middle of a byte while another byte is offered.
    sel = 1;
    do_flush(1);
    send(1, 8'h3C);
    idle(6);
    flush[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 8'h99;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready[1]), 32'd0);
    @(posedge clk); #1;
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    n0 = strb_cyc.size();
    a0 = acc_cyc.size();
    @(negedge clk);
    check("flush_busy", 32'(busy[1]), 32'd0);
    check("flush_clken", 32'(sr_clken[1]), 32'd0);
    idle(30);
    check("flush_no_strobe", 32'(strb_cyc.size()), 32'(n0));
    check("flush_dropped", 32'(acc_cyc.size()), 32'(a0));

    // Bit order for 0x01.
    sel = 0;
    do_flush(0);
    send(0, 8'h01);
    idle(15);
    check_stream("order01", 1);
    if (strb_bit.size() == 8) begin
`ifdef LSB_FIRST_EN
      check("order01_first", 32'(strb_bit[0]), 32'd1);
`else
      check("order01_last", 32'(strb_bit[7]), 32'd1);
`endif
    end

    // Random bytes with random gaps on both pacings.
    for (int r = 0; r < 4; r++) begin
      sel = r % 2;
      do_flush(sel);
      nb = $urandom_range(4, 20);
      for (int i = 0; i < nb; i++) begin
        gap = $urandom_range(0, 12);
        if (gap > 0) idle(gap);
        b = 8'($urandom);
        send(sel, b);
      end
      idle(60);
      check_stream((sel == 0) ? "rand_div1" : "rand_div3", (sel == 0) ? 1 : 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
